// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage: holds busy for the architectural
// latency of mult/div, then commits the pending result to HI/LO.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [31:0]   phi, plo;
    logic          pwr;

    op_e  opc;
    logic accept, is_mul, is_div, div_zero;
    logic [31:0] res_hi, res_lo;

    assign opc      = op_e'(op);
    assign busy     = (state_q == RUN);
    assign accept   = start & ~cancel & ~busy;
    assign is_mul   = (opc == OP_MULT) || (opc == OP_MULTU);
    assign is_div   = (opc == OP_DIV)  || (opc == OP_DIVU);
    assign div_zero = (b == 32'd0);

    // Arithmetic is evaluated every cycle; only the issue cycle's result is latched.
    logic signed [63:0] smul;
    logic        [63:0] umul;
    logic        [31:0] divisor;
    logic signed [31:0] sa, sb, sq, sr;
    logic        [31:0] uq, ur;
    logic               sdiv_ovf;

    assign smul     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul     = {32'd0, a} * {32'd0, b};
    assign divisor  = div_zero ? 32'd1 : b;
    assign sa       = $signed(a);
    assign sb       = $signed(divisor);
    assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sq       = sdiv_ovf ? 32'sh8000_0000 : sa / sb;
    assign sr       = sdiv_ovf ? 32'sd0 : sa % sb;
    assign uq       = a / divisor;
    assign ur       = a % divisor;

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (opc)
            OP_MULT:  {res_hi, res_lo} = smul;
            OP_MULTU: {res_hi, res_lo} = umul;
            OP_DIV:   begin res_hi = sr; res_lo = sq; end
            OP_DIVU:  begin res_hi = ur; res_lo = uq; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && (is_mul || is_div)) state_d = RUN;
            RUN:     if (cnt == CW'(1))                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            phi <= 32'd0;
            plo <= 32'd0;
            pwr <= 1'b0;
            hi  <= 32'd0;
            lo  <= 32'd0;
        end else if (state_q == IDLE) begin
            if (accept && (is_mul || is_div)) begin
                cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                phi <= res_hi;
                plo <= res_lo;
                // Divide by zero still runs the full window but leaves HI/LO alone.
                pwr <= ~(is_div && div_zero);
            end else if (accept && opc == OP_MTHI) begin
                hi <= a;
            end else if (accept && opc == OP_MTLO) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && pwr) begin
                hi <= phi;
                lo <= plo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return 5;
        if (o == 3'd3 || o == 3'd4) return 10;
        return 0;
    endfunction

    // Reference behaviour straight from the arithmetic definitions.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sp, q, r;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o)
            3'd1: begin sp = sx * sy; model_hi = sp[63:32]; model_lo = sp[31:0]; end
            3'd2: begin up = ux * uy; model_hi = up[63:32]; model_lo = up[31:0]; end
            3'd3: if (y != 0) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    model_lo = 32'h8000_0000; model_hi = 32'd0;
                end else begin
                    q = sx / sy; r = sx % sy;
                    model_lo = q[31:0]; model_hi = r[31:0];
                end
            end
            3'd4: if (y != 0) begin model_lo = x / y; model_hi = x % y; end
            3'd5: model_hi = x;
            3'd6: model_lo = x;
            default: ;
        endcase
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first idle cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic c, output int n);
        start = 1'b1; op = o; a = x; b = y; cancel = c;
        @(negedge clk);
        start = 1'b0; op = 3'd0; cancel = 1'b0;
        a = $urandom; b = $urandom;
        wait_idle(n);
    endtask

    initial begin
        int n, m;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{3'd5, 32'h0000_1234, 32'h0000_0000, 0,  32'h0000_1234, 32'h8000_0000};
        vecs[6] = '{3'd6, 32'h0000_5678, 32'h0000_0000, 0,  32'h0000_1234, 32'h0000_5678};
        vecs[7] = '{3'd3, 32'h0000_0005, 32'h0000_0000, 10, 32'h0000_1234, 32'h0000_5678};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, n);
            model_apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d cycles", i), 64'(n), 64'(vecs[i].cyc));
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
        end

        // start together with cancel is fully suppressed
        run_op(3'd1, 32'd3, 32'd4, 1'b1, n);
        check("cancel mult cycles", 64'(n), 64'd0);
        check("cancel mult hi", 64'(hi), 64'h1234);
        check("cancel mult lo", 64'(lo), 64'h5678);
        run_op(3'd5, 32'hAAAA, 32'd0, 1'b1, n);
        check("cancel mthi cycles", 64'(n), 64'd0);
        check("cancel mthi hi", 64'(hi), 64'h1234);

        // cancel pulsed during RUN is ignored
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        wait_idle(n);
        check("run cancel cycles", 64'(n + 2), 64'd5);
        check("run cancel hi", 64'(hi), 64'd0);
        check("run cancel lo", 64'(lo), 64'd12);

        // issues while busy are dropped; then back-to-back in the first idle cycle
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = 3'd6; a = 32'hFFFF;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        wait_idle(n);
        check("busy drop cycles", 64'(n + 3), 64'd5);
        check("busy drop hi", 64'(hi), 64'd0);
        check("busy drop lo", 64'(lo), 64'd12);
        run_op(3'd4, 32'd100, 32'd7, 1'b0, n);
        check("reissue cycles", 64'(n), 64'd10);
        check("reissue hi", 64'(hi), 64'd2);
        check("reissue lo", 64'(lo), 64'd14);

        // reset in busy cycle 3 aborts the op with no later commit
        start = 1'b1; op = 3'd1; a = 32'h1_0000; b = 32'h1_0000;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rst mid busy c%0d", k), 64'(busy), 64'd0);
            check($sformatf("rst mid hi c%0d", k), 64'(hi), 64'd0);
            check($sformatf("rst mid lo c%0d", k), 64'(lo), 64'd0);
            @(negedge clk);
        end

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ((ro == 3'd3 || ro == 3'd4) && $urandom_range(0, 1) == 1)
                rb = 32'($urandom_range(1, 20));
            rc = ($urandom_range(0, 7) == 0);
            run_op(ro, ra, rb, rc, n);
            m = rc ? 0 : exp_cycles(ro);
            if (!rc) model_apply(ro, ra, rb);
            check($sformatf("rand%0d op%0d cycles", i, ro), 64'(n), 64'(m));
            check($sformatf("rand%0d op%0d hi", i, ro), 64'(hi), 64'(model_hi));
            check($sformatf("rand%0d op%0d lo", i, ro), 64'(lo), 64'(model_lo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide unit with its sequencing controller, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo issues, holds a busy window for the architectural latency, and commits results to HI/LO at the end of that window. The hazard unit stalls the pipeline using `busy`/`start`. The block also honours a same-cycle cancel from the exception/interrupt logic, so flushed instructions never touch HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue strobe for the E-stage MDU instruction
- op  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  in  32  rs operand / dividend / mthi-mtlo source
- b  in  32  rt operand / divisor
- cancel  in  1  flush of the E-stage instruction this cycle
- busy  out  1  operation in progress
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- Accepted issue: `start & ~cancel & ~busy & op != 0,7`. Any other `start` is ignored with no state change.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; down-counter `cnt` and pending result `{phi, plo}` registered.
- IDLE→RUN on an accepted mult/multu/div/divu:
  - Latch the result computed from `a`/`b` in that cycle.
  - Load `cnt` = MULT_CYCLES or DIV_CYCLES.
- RUN:
  - Decrement `cnt` each cycle.
  - When `cnt`==1: commit `{phi, plo}` to `{hi, lo}`; next state IDLE.
- Accepted mthi/mtlo, IDLE only: hi←a or lo←a at the next edge; no busy.
- mult: signed 32×32→64; hi=upper, lo=lower. multu: unsigned.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b==0): the full DIV_CYCLES busy window still runs; hi/lo are left unchanged at commit.
- `cancel` while already RUN has no effect. An issued operation always completes.
- Operands are sampled only at issue. Later changes to `a`/`b` are irrelevant.

## Timing
- Reset values: busy=0, hi=0, lo=0, state IDLE, cnt=0, pending result cleared.
- Reset during RUN: the next cycle is IDLE with hi=lo=0. No commit occurs.
- Issue at edge t:
  - busy=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo are visible from cycle t+N+1, the same cycle busy falls.
- mthi/mtlo issued at edge t: value visible from t+1.
- back-to-back: a new issue is accepted in the first cycle busy=0.
- Hazard unit stalls any MDU instruction in E while `busy | start`. The block itself never relies on this: issues while busy are dropped.
- `start` and `cancel` both high: the issue is fully suppressed, including mthi/mtlo.

## Test plan
- **mult / multu:**
  - mult a=0xFFFFFFFF, b=0x00000002 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- **div / divu:**
  - div a=0xFFFFFFF9 (−7), b=2 → busy exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7, b=2 → lo=3, hi=1.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **Divide by zero:** mthi 0x1234, mtlo 0x5678, then div a=5, b=0 → busy 10 cycles; afterwards hi=0x1234, lo=0x5678.
- **Cancel:**
  - start+cancel with mult 3×4 → busy stays 0; hi/lo unchanged.
  - start+cancel with mthi 0xAAAA → hi unchanged.
  - cancel pulsed during RUN of mult 3×4 → commit still yields lo=12, hi=0.
- **Issue while busy:** mult 3×4 issued, then at busy cycle 2 issue divu 100/7 and mtlo 0xFFFF → both ignored; final lo=12, hi=0. An immediate re-issue of divu in the first idle cycle yields lo=14, hi=2 after 10 busy cycles.
- **Reset mid-op:** mult 0x10000×0x10000 issued, reset asserted in busy cycle 3 → following cycle busy=0, hi=lo=0. Both stay 0 through cycle t+10 (no stray commit).
